// File: rtl/alu_disp_sched.sv
// alu_disp_sched: display scheduler between the ALU result producer and the
// 4-bit signed-result seven-segment decoder. Results are queued in a small
// FIFO and each one is held on res_num for HOLD_CYCLES clocks, so bursts of
// results stay readable on the board displays.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   clr        synchronous flush of FIFO and display (below rst in priority)
//   in_valid   producer offers in_data this cycle
//   in_data    ALU result (bit3 sign, bits2:0 magnitude), passed through as-is
//   in_ready   FIFO can accept (not full, from the registered count)
//   res_num    registered value fed to the decoder
//   disp_blank 1 while nothing has been loaded; display forces segments off
//   disp_new   one-cycle pulse in the cycle after res_num is loaded
//   fifo_count current FIFO occupancy (0..DEPTH)
module alu_disp_sched #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [3:0]               in_data,
  output logic                     in_ready,
  output logic [3:0]               res_num,
  output logic                     disp_blank,
  output logic                     disp_new,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] HOLD_ONE = CW'(1);
  localparam logic [CW-1:0] RELOAD   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] hold_cnt;
  logic          push;
  logic          pop;
  logic          empty;

  assign in_ready   = (count != CNT_FULL);
  assign empty      = (count == '0);
  // A flush or reset on the same edge drops the offered value.
  assign push       = in_valid && in_ready && !clr && !rst;
  assign fifo_count = count;

  // The scheduler only sees entries already in the FIFO before the edge,
  // so a value written this edge is never loaded on the same edge.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = SHOW;
        end
      end
      SHOW: begin
        if (hold_cnt == '0) begin
          if (!empty) pop = 1'b1;
          else        state_nx = HOLD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) state <= IDLE;
    else            state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      hold_cnt   <= '0;
      res_num    <= '0;
      disp_blank <= 1'b1;
      disp_new   <= 1'b0;
    end else begin
      disp_new <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        res_num    <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + PTR_ONE;
        disp_blank <= 1'b0;
        hold_cnt   <= RELOAD;
      end else if (state == SHOW && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_disp_sched.sv
module tb_alu_disp_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       v   = 1'b0;
  logic [3:0] d   = '0;
  logic       rdy, blank, dnew;
  logic [3:0] res;
  logic [2:0] cnt;

  logic       clr1 = 1'b0;
  logic       v1   = 1'b0;
  logic [3:0] d1   = '0;
  logic       rdy1, blank1, dnew1;
  logic [3:0] res1;
  logic [2:0] cnt1;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_q1[$];

  always #5 clk = ~clk;

  alu_disp_sched #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(v), .in_data(d),
    .in_ready(rdy), .res_num(res), .disp_blank(blank), .disp_new(dnew),
    .fifo_count(cnt)
  );

  alu_disp_sched #(.DEPTH(4), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .in_valid(v1), .in_data(d1),
    .in_ready(rdy1), .res_num(res1), .disp_blank(blank1), .disp_new(dnew1),
    .fifo_count(cnt1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboards: every load pulse must show the oldest accepted value.
  always @(negedge clk) begin : mon0
    logic [3:0] e;
    if (dnew === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_extra: got res_num %0h expected no load", res);
      end else begin
        e = exp_q.pop_front();
        chk("sb_order", 32'(res), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [3:0] e;
    if (dnew1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1_extra: got res_num %0h expected no load", res1);
      end else begin
        e = exp_q1.pop_front();
        chk("sb1_order", 32'(res1), 32'(e));
      end
    end
  end

  typedef struct {
    bit         r, c, vv;
    logic [3:0] dd;
    bit         acc;
    logic [3:0] e_res;
    bit         e_blank, e_new, e_rdy;
    logic [2:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit c, bit vv, logic [3:0] dd, bit acc,
                              logic [3:0] er, bit eb, bit en, bit erd, logic [2:0] ec);
    vec_t t;
    t.r = r; t.c = c; t.vv = vv; t.dd = dd; t.acc = acc;
    t.e_res = er; t.e_blank = eb; t.e_new = en; t.e_rdy = erd; t.e_cnt = ec;
    return t;
  endfunction

  task automatic put(input bit vv, input logic [3:0] dd, input bit acc);
    v = vv; d = dd;
    if (vv && acc) exp_q.push_back(dd);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cyc(input bit vv, input logic [3:0] dd, input bit acc);
    put(vv, dd, acc);
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) cyc(1'b0, 4'h0, 1'b0);
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (6) cyc(1'b0, 4'h0, 1'b0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    // rst held 2 cycles with a value offered: nothing is captured
    tbl.push_back(mk(1,0,1,4'h9,0, 4'h0,1,0,1,3'd0));
    tbl.push_back(mk(1,0,1,4'h9,0, 4'h0,1,0,1,3'd0));
    tbl.push_back(mk(0,0,0,4'h0,0, 4'h0,1,0,1,3'd0));
    // single result 4'b1011 pushed at E, shown at E+1, then HOLD
    tbl.push_back(mk(0,0,1,4'hB,1, 4'h0,1,0,1,3'd1));
    tbl.push_back(mk(0,0,0,4'h0,0, 4'hB,0,1,1,3'd0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,4'h0,0, 4'hB,0,0,1,3'd0));
    // burst 1,2,3: loads at F+1, F+5, F+9
    tbl.push_back(mk(0,0,1,4'h1,1, 4'hB,0,0,1,3'd1));
    tbl.push_back(mk(0,0,1,4'h2,1, 4'h1,0,1,1,3'd1));
    tbl.push_back(mk(0,0,1,4'h3,1, 4'h1,0,0,1,3'd2));
    tbl.push_back(mk(0,0,0,4'h0,0, 4'h1,0,0,1,3'd2));
    tbl.push_back(mk(0,0,0,4'h0,0, 4'h1,0,0,1,3'd2));
    tbl.push_back(mk(0,0,0,4'h0,0, 4'h2,0,1,1,3'd1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,4'h0,0, 4'h2,0,0,1,3'd1));
    tbl.push_back(mk(0,0,0,4'h0,0, 4'h3,0,1,1,3'd0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,4'h0,0, 4'h3,0,0,1,3'd0));

    foreach (tbl[i]) begin
      rst = tbl[i].r; clr = tbl[i].c;
      put(tbl[i].vv, tbl[i].dd, tbl[i].acc);
      step();
      if (tbl[i].r || tbl[i].c) exp_q.delete();
      chk($sformatf("t%0d_res", i),   32'(res),   32'(tbl[i].e_res));
      chk($sformatf("t%0d_blank", i), 32'(blank), 32'(tbl[i].e_blank));
      chk($sformatf("t%0d_new", i),   32'(dnew),  32'(tbl[i].e_new));
      chk($sformatf("t%0d_rdy", i),   32'(rdy),   32'(tbl[i].e_rdy));
      chk($sformatf("t%0d_cnt", i),   32'(cnt),   32'(tbl[i].e_cnt));
    end
    rst = 1'b0; clr = 1'b0;

    // Backpressure: first value goes to the display, next four fill the FIFO
    cyc(1'b1, 4'hA, 1'b1);
    cyc(1'b1, 4'hC, 1'b1);
    cyc(1'b1, 4'h5, 1'b1);
    cyc(1'b1, 4'hE, 1'b1);
    cyc(1'b1, 4'h6, 1'b1);
    chk("full_cnt", 32'(cnt), 32'd4);
    chk("full_rdy", 32'(rdy), 32'd0);
    // offered while full, on the same edge as a pop: must be dropped
    cyc(1'b1, 4'hF, 1'b0);
    chk("full_pop_cnt", 32'(cnt), 32'd3);
    chk("full_pop_rdy", 32'(rdy), 32'd1);
    chk("full_pop_new", 32'(dnew), 32'd1);
    chk("full_pop_res", 32'(res), 32'hC);
    drain();
    chk("drain_res", 32'(res), 32'h6);
    chk("drain_cnt", 32'(cnt), 32'd0);
    chk("drain_blank", 32'(blank), 32'd0);
    // further pushes, read/write pointers now well past a wrap
    cyc(1'b1, 4'h2, 1'b1);
    cyc(1'b1, 4'h9, 1'b1);
    cyc(1'b1, 4'h4, 1'b1);
    drain();
    chk("wrap_res", 32'(res), 32'h4);

    // Flush in SHOW with three queued and a coincident push
    cyc(1'b1, 4'h1, 1'b1);
    cyc(1'b1, 4'h2, 1'b1);
    cyc(1'b1, 4'h3, 1'b1);
    cyc(1'b1, 4'h4, 1'b1);
    chk("pre_clr_cnt", 32'(cnt), 32'd3);
    clr = 1'b1;
    put(1'b1, 4'hD, 1'b0);
    step();
    exp_q.delete();
    clr = 1'b0;
    chk("clr_blank", 32'(blank), 32'd1);
    chk("clr_res", 32'(res), 32'h0);
    chk("clr_cnt", 32'(cnt), 32'd0);
    chk("clr_rdy", 32'(rdy), 32'd1);
    chk("clr_new", 32'(dnew), 32'd0);
    cyc(1'b0, 4'h0, 1'b0);
    chk("clr_idle_blank", 32'(blank), 32'd1);
    chk("clr_idle_cnt", 32'(cnt), 32'd0);
    cyc(1'b1, 4'h7, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("post_clr_res", 32'(res), 32'h7);
    chk("post_clr_new", 32'(dnew), 32'd1);
    chk("post_clr_blank", 32'(blank), 32'd0);
    repeat (6) cyc(1'b0, 4'h0, 1'b0);

    // HOLD_CYCLES = 1: back-to-back loads
    v1 = 1'b1; d1 = 4'h7; exp_q1.push_back(4'h7);
    step();
    chk("h1_e0_cnt", 32'(cnt1), 32'd1);
    chk("h1_e0_blank", 32'(blank1), 32'd1);
    d1 = 4'h6; exp_q1.push_back(4'h6);
    step();
    chk("h1_e1_res", 32'(res1), 32'h7);
    chk("h1_e1_new", 32'(dnew1), 32'd1);
    d1 = 4'h5; exp_q1.push_back(4'h5);
    step();
    chk("h1_e2_res", 32'(res1), 32'h6);
    chk("h1_e2_new", 32'(dnew1), 32'd1);
    v1 = 1'b0;
    step();
    chk("h1_e3_res", 32'(res1), 32'h5);
    chk("h1_e3_new", 32'(dnew1), 32'd1);
    step();
    chk("h1_e4_res", 32'(res1), 32'h5);
    chk("h1_e4_new", 32'(dnew1), 32'd0);
    repeat (3) step();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("sb1_empty", 32'(exp_q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_disp_sched.md
Name: alu_disp_sched

Overview:
Display scheduler that sits between the ALU result producer and the 4-bit signed-result seven-segment decoder. It buffers ALU results in a small FIFO and presents each one on `res_num` for a fixed dwell time. This keeps bursts of results readable on the board displays. It also drives a blank flag so the display path can suppress the decoder output when there is nothing to show.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2
- HOLD_CYCLES, 16, clock cycles each result stays on `res_num` before the next may replace it; minimum 1

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- clr  input  1  synchronous flush of FIFO and display; lower priority than rst
- in_valid  input  1  producer offers in_data this cycle
- in_data  input  4  ALU result: bit3 sign, bits2:0 magnitude code, passed through unmodified
- in_ready  output  1  FIFO can accept; equals !full from registered count
- res_num  output  4  value fed to decoder; registered
- disp_blank  output  1  1 = nothing loaded; display path forces all segments off
- disp_new  output  1  one-cycle pulse in the cycle after a new value is loaded into res_num
- fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values, checked in the cycle after rst is sampled high:
  - state = IDLE
  - FIFO empty; read and write pointers = 0
  - fifo_count = 0
  - in_ready = 1
  - res_num = 4'b0000
  - disp_blank = 1
  - disp_new = 0
  - hold counter = 0
- rst mid-operation discards all buffered and displayed data.
- clr produces the same end state as rst. If clr and a push coincide, the push is dropped.
- Push rule:
  - A push happens at an edge where in_valid && in_ready.
  - in_ready is derived from the count before that edge.
  - When full, in_ready = 0 even if a pop occurs on the same edge. No push-through.
- Pop: only the scheduler pops, and only when it loads the display register.
- Simultaneous push and pop (not full, not empty): count is unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- State IDLE, disp_blank = 1:
  - If FIFO non-empty at an edge: pop head into res_num, set disp_blank = 0, pulse disp_new, load counter = HOLD_CYCLES-1, go to SHOW.
- State SHOW:
  - Each edge with counter != 0: decrement.
  - Edge with counter == 0 and FIFO non-empty: pop into res_num, pulse disp_new, reload counter, stay in SHOW.
  - Edge with counter == 0 and FIFO empty: go to HOLD; res_num is kept.
- State HOLD:
  - res_num is displayed indefinitely.
  - If FIFO non-empty at an edge: pop and load as in IDLE, then go to SHOW.
- Timing:
  - Each loaded value stays on res_num for exactly HOLD_CYCLES cycles when followed by queued data.
  - Latency from a push accepted at edge E into an empty FIFO while in IDLE or HOLD: res_num updates at edge E+1.
  - The pushed value is not visible to the scheduler on the same edge it is written. No bypass.
- HOLD_CYCLES = 1: back-to-back loads on consecutive edges while the FIFO is non-empty.
- Data path is 4-bit opaque: no arithmetic, no sign extension.
- Count width is clog2(DEPTH)+1 so that full (count == DEPTH) is representable.
- No illegal-state recovery is needed beyond the default transition to IDLE.

Test Plan (DEPTH=4, HOLD_CYCLES=4 unless stated):
- Reset/idle: assert rst 2 cycles with in_valid=1 → in the cycle after rst deasserts: res_num=0, disp_blank=1, fifo_count=0, in_ready=1; nothing from the reset cycles is pushed.
- Single result: push 4'b1011 at edge E → at E+1: res_num=4'b1011, disp_blank=0, disp_new high for one cycle; at E+5: state HOLD, res_num still 4'b1011, no further disp_new.
- Burst/dwell: push 1,2,3 on consecutive edges E..E+2 → res_num=1 at E+1, 2 at E+5, 3 at E+9; exactly one disp_new pulse per load; fifo_count peaks at 2.
- Full/backpressure: with the display stalled in SHOW, push 5 values on consecutive cycles → first loads into the display; next 4 fill the FIFO (fifo_count=4, in_ready=0); a 6th offered value is not accepted and is never displayed even when a pop coincides; wrap check: after 8+ total pushes, values emerge in push order.
- Flush: assert clr while in SHOW with fifo_count=3 and in_valid=1 → next cycle: disp_blank=1, res_num=0, fifo_count=0, IDLE; the coincident push is absent.
- HOLD_CYCLES=1: push 7,6,5 back-to-back → res_num = 7, 6, 5 on consecutive edges starting at E+1; disp_new high for 3 consecutive cycles.
